// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: pipeline MEM stage vs DMA burst engine.
// Single owner per cycle, DMA starvation guard, 1-cycle read-data routing.
module dmem_arbiter #(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int LEN_W        = 5,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_req,
  input  logic              p_we,
  input  logic [ADDR_W-1:0] p_addr,
  input  logic [DATA_W-1:0] p_wdata,
  output logic              p_stall,
  output logic [DATA_W-1:0] p_rdata,
  output logic              p_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LEN_W-1:0]  d_len,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_done,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WC_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [WC_W-1:0] LIMIT = WC_W'(STARVE_LIMIT);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state;
  logic [WC_W-1:0]   wait_cnt;
  logic [LEN_W-1:0]  remain;
  logic [ADDR_W-1:0] baddr;
  logic              bwe;
  logic              rd_p;
  logic              rd_d;
  logic              done_q;

  logic              d_pri;
  logic              grant_p;
  logic              grant_d;
  logic              beat;
  logic              beat_we;
  logic [LEN_W-1:0]  len_m1;

  assign len_m1 = (d_len == '0) ? '0 : d_len - 1'b1;

  always_comb begin
    d_pri   = 1'b0;
    grant_p = 1'b0;
    grant_d = 1'b0;
    if (state == IDLE) begin
      d_pri   = d_req && (wait_cnt >= LIMIT);
      grant_p = p_req && !d_pri;
      grant_d = d_req && !grant_p;
    end
    beat    = grant_d || (state == BURST);
    beat_we = (state == BURST) ? bwe : d_we;
  end

  // Outputs are forced low while reset is held, even mid-cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (rst_n && grant_p) begin
      mem_en    = 1'b1;
      mem_we    = p_we;
      mem_addr  = p_addr;
      mem_wdata = p_wdata;
    end else if (rst_n && beat) begin
      mem_en    = 1'b1;
      mem_we    = beat_we;
      mem_addr  = (state == BURST) ? baddr : d_addr;
      mem_wdata = d_wdata;
    end
  end

  assign p_stall  = rst_n && p_req && !grant_p;
  assign d_gnt    = rst_n && beat;
  assign p_rvalid = rd_p;
  assign d_rvalid = rd_d;
  assign p_rdata  = rd_p ? mem_rdata : '0;
  assign d_rdata  = rd_d ? mem_rdata : '0;
  assign d_done   = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      remain   <= '0;
      baddr    <= '0;
      bwe      <= 1'b0;
      rd_p     <= 1'b0;
      rd_d     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rd_p   <= grant_p && !p_we;
      rd_d   <= beat && !beat_we;
      if (!d_req || grant_d)
        wait_cnt <= '0;
      else if (grant_p && wait_cnt < LIMIT)
        wait_cnt <= wait_cnt + WC_W'(1);
      case (state)
        IDLE: begin
          if (grant_d) begin
            baddr  <= d_addr + 1'b1;
            bwe    <= d_we;
            remain <= len_m1;
            if (len_m1 != '0) state <= BURST;
            else done_q <= 1'b1;
          end
        end
        BURST: begin
          baddr  <= baddr + 1'b1;
          remain <= remain - 1'b1;
          if (remain == LEN_W'(1)) begin
            state  <= IDLE;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 1K x 32 memory.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p_req, p_we;
  logic [9:0]  p_addr;
  logic [31:0] p_wdata;
  logic        p_stall, p_rvalid;
  logic [31:0] p_rdata;
  logic        d_req, d_we;
  logic [9:0]  d_addr;
  logic [4:0]  d_len;
  logic [31:0] d_wdata;
  logic        d_gnt, d_rvalid, d_done;
  logic [31:0] d_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] ram [0:1023];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end
  end

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rdata(p_rdata), .p_rvalid(p_rvalid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_len(d_len),
    .d_wdata(d_wdata), .d_gnt(d_gnt), .d_rdata(d_rdata),
    .d_rvalid(d_rvalid), .d_done(d_done),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic p_drive(input logic req, input logic we,
                         input logic [9:0] a, input logic [31:0] wd);
    p_req = req; p_we = we; p_addr = a; p_wdata = wd;
  endtask

  initial begin
    rst_n = 1'b0;
    p_drive(1'b0, 1'b0, '0, '0);
    d_req = 0; d_we = 0; d_addr = '0; d_len = '0; d_wdata = '0;
    mem_rdata = '0;

    // Reset state
    @(negedge clk);
    chk("rst_p_stall", {31'd0, p_stall}, 0);
    chk("rst_d_gnt", {31'd0, d_gnt}, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_d_done", {31'd0, d_done}, 0);
    chk("rst_p_rvalid", {31'd0, p_rvalid}, 0);
    step();
    rst_n = 1'b1;

    // P write then P read
    step();
    p_drive(1, 1, 10'h005, 32'hDEADBEEF);
    @(negedge clk);
    chk("pw_stall", {31'd0, p_stall}, 0);
    chk("pw_mem_we", {31'd0, mem_we}, 1);
    chk("pw_mem_addr", {22'd0, mem_addr}, 32'h005);
    step();
    p_drive(1, 0, 10'h005, '0);
    @(negedge clk);
    chk("pr_stall", {31'd0, p_stall}, 0);
    chk("pr_no_rvalid_yet", {31'd0, p_rvalid}, 0);
    step();
    p_drive(0, 0, '0, '0);
    @(negedge clk);
    chk("pr_rvalid", {31'd0, p_rvalid}, 1);
    chk("pr_rdata", p_rdata, 32'hDEADBEEF);
    chk("pr_d_rvalid", {31'd0, d_rvalid}, 0);
    chk("idle_mem_en", {31'd0, mem_en}, 0);
    chk("idle_mem_addr", {22'd0, mem_addr}, 0);

    // D write burst with address wrap
    step();
    d_req = 1; d_we = 1; d_addr = 10'h3FE; d_len = 5'd4;
    for (int i = 0; i < 4; i++) begin
      d_wdata = 32'hA0A0_0000 + i;
      @(negedge clk);
      chk($sformatf("dw_gnt%0d", i), {31'd0, d_gnt}, 1);
      chk($sformatf("dw_addr%0d", i), {22'd0, mem_addr},
          (i == 0) ? 32'h3FE : (i == 1) ? 32'h3FF : (i == 2) ? 32'h000 : 32'h001);
      chk($sformatf("dw_done%0d", i), {31'd0, d_done}, 0);
      step();
      d_req = 0;
    end
    @(negedge clk);
    chk("dw_done", {31'd0, d_done}, 1);
    chk("dw_gnt_end", {31'd0, d_gnt}, 0);
    step();
    p_drive(1, 0, 10'h000, '0);
    step();
    p_drive(0, 0, '0, '0);
    @(negedge clk);
    chk("dw_wrap_rd", p_rdata, 32'hA0A0_0002);

    // Starvation guard
    step();
    p_drive(1, 0, 10'h3FE, '0);
    d_req = 1; d_we = 1; d_addr = 10'h100; d_len = 5'd2; d_wdata = 32'h1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sv_p_gnt%0d", k), {31'd0, d_gnt}, 0);
      chk($sformatf("sv_p_stall%0d", k), {31'd0, p_stall}, 0);
      step();
    end
    @(negedge clk);
    chk("sv_d_gnt0", {31'd0, d_gnt}, 1);
    chk("sv_stall0", {31'd0, p_stall}, 1);
    chk("sv_addr0", {22'd0, mem_addr}, 32'h100);
    step();
    d_req = 0;
    @(negedge clk);
    chk("sv_d_gnt1", {31'd0, d_gnt}, 1);
    chk("sv_stall1", {31'd0, p_stall}, 1);
    chk("sv_addr1", {22'd0, mem_addr}, 32'h101);
    step();
    @(negedge clk);
    chk("sv_resume_stall", {31'd0, p_stall}, 0);
    chk("sv_resume_addr", {22'd0, mem_addr}, 32'h3FE);
    chk("sv_done", {31'd0, d_done}, 1);
    step();
    p_drive(0, 0, '0, '0);

    // D read burst over preloaded words
    for (int i = 0; i < 3; i++) begin
      p_drive(1, 1, 10'h010 + 10'(i), 32'h11 * (i + 1));
      step();
    end
    p_drive(0, 0, '0, '0);
    d_req = 1; d_we = 0; d_addr = 10'h010; d_len = 5'd3;
    @(negedge clk);
    chk("dr_gnt0", {31'd0, d_gnt}, 1);
    chk("dr_rvalid0", {31'd0, d_rvalid}, 0);
    step();
    d_req = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("dr_rvalid%0d", i + 1), {31'd0, d_rvalid}, 1);
      chk($sformatf("dr_rdata%0d", i + 1), d_rdata, 32'h11 * (i + 1));
      chk($sformatf("dr_p_rvalid%0d", i + 1), {31'd0, p_rvalid}, 0);
      chk($sformatf("dr_done%0d", i + 1), {31'd0, d_done}, (i == 2) ? 1 : 0);
      step();
    end

    // d_len = 0 is a single beat
    d_req = 1; d_we = 1; d_addr = 10'h020; d_len = 5'd0; d_wdata = 32'hC0;
    @(negedge clk);
    chk("l0_gnt", {31'd0, d_gnt}, 1);
    chk("l0_addr", {22'd0, mem_addr}, 32'h020);
    step();
    d_req = 0;
    @(negedge clk);
    chk("l0_no_beat2", {31'd0, d_gnt}, 0);
    chk("l0_done", {31'd0, d_done}, 1);
    chk("l0_mem_en", {31'd0, mem_en}, 0);
    step();

    // Reset mid-burst
    p_drive(1, 1, 10'h202, 32'h5A5A5A5A);
    step();
    p_drive(0, 0, '0, '0);
    d_req = 1; d_we = 1; d_addr = 10'h200; d_len = 5'd8;
    d_wdata = 32'hB0;
    step();
    d_req = 0;
    d_wdata = 32'hB1;
    step();
    d_wdata = 32'hB2;
    #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rb_gnt", {31'd0, d_gnt}, 0);
    chk("rb_mem_en", {31'd0, mem_en}, 0);
    chk("rb_mem_we", {31'd0, mem_we}, 0);
    chk("rb_mem_addr", {22'd0, mem_addr}, 0);
    step();
    @(negedge clk);
    chk("rb_no_done", {31'd0, d_done}, 0);
    step();
    rst_n = 1'b1;
    p_drive(1, 0, 10'h201, '0);
    @(negedge clk);
    chk("rb_p_stall", {31'd0, p_stall}, 0);
    chk("rb_no_gnt", {31'd0, d_gnt}, 0);
    step();
    p_drive(1, 0, 10'h202, '0);
    @(negedge clk);
    chk("rb_beat1", p_rdata, 32'hB1);
    step();
    p_drive(0, 0, '0, '0);
    @(negedge clk);
    chk("rb_beat2_kept", p_rdata, 32'h5A5A5A5A);
    chk("rb_no_done2", {31'd0, d_done}, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
